// File: rtl/dpi_panel_pkg.sv
// Shared types and constants for the DPI panel power/enable sequencer.
package dpi_panel_pkg;
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_UP   = 3'd1,
    ST_VIDEO    = 3'd2,
    ST_ON       = 3'd3,
    ST_BL_DOWN  = 3'd4,
    ST_PWR_DOWN = 3'd5
  } panel_state_e;

  localparam int PWM_BITS_DEF = 8;
  localparam int FADE_STEP    = 16;
endpackage

// File: rtl/panel_bl_pwm.sv
// Backlight PWM: free-running counter, frame-latched level, registered compare.
// BL_FADE_EN: level ramps toward the target by FADE_STEP per vsync edge.
module panel_bl_pwm
  import dpi_panel_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_edge,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                bl_en,
`ifdef BL_FADE_EN
  input  logic                fade_run,
  input  logic                fade_down,
  output logic                bl_zero,
`endif
  output logic                bl_pwm
);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bl_lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      bl_pwm  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      bl_pwm  <= bl_en & (pwm_cnt < bl_lvl);
    end
  end

`ifdef BL_FADE_EN
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);
  logic [PWM_BITS-1:0] target;
  assign target  = fade_down ? '0 : brightness;
  assign bl_zero = (bl_lvl == '0);

  // Outside ON/BL_DOWN the level is held at 0 so ON always ramps up from dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bl_lvl <= '0;
    else if (!fade_run)
      bl_lvl <= '0;
    else if (vs_edge) begin
      if (bl_lvl < target)
        bl_lvl <= ((target - bl_lvl) > STEP) ? bl_lvl + STEP : target;
      else
        bl_lvl <= ((bl_lvl - target) > STEP) ? bl_lvl - STEP : target;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bl_lvl <= '0;
    else if (vs_edge)
      bl_lvl <= brightness;
  end
`endif
endmodule

// File: rtl/dpi_panel_sequencer.sv
// Frame-counted power/video/backlight sequencer for the DPI panel.
// Optional BL_FADE_EN: backlight fades in/out before power-down proceeds.
module dpi_panel_sequencer
  import dpi_panel_pkg::*;
#(
  parameter int PWR_FRAMES   = 2,
  parameter int VIDEO_FRAMES = 4,
  parameter int PWM_BITS     = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                timing_ok,
  input  logic                vsync,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                panel_pwr,
  output logic                video_en,
  output logic                bl_en,
  output logic                bl_pwm,
  output logic                ready,
  output logic [2:0]          state
);
  localparam logic [7:0] PWR_LAST = 8'(PWR_FRAMES - 1);
  localparam logic [7:0] VID_LAST = 8'(VIDEO_FRAMES - 1);

  panel_state_e state_q, nxt;
  logic [7:0]   frame_cnt;
  logic         vsync_q, vs_edge, pwr_hit, vid_hit, bl_done;

  assign vs_edge = vsync & ~vsync_q;
  assign pwr_hit = vs_edge && (frame_cnt >= PWR_LAST);
  assign vid_hit = vs_edge && (frame_cnt >= VID_LAST);
  assign state   = state_q;

`ifdef BL_FADE_EN
  logic bl_zero;
  assign bl_done = vid_hit && bl_zero;
`else
  assign bl_done = vid_hit;
`endif

  always_comb begin
    nxt = state_q;
    unique case (state_q)
      ST_OFF:      if (enable) nxt = ST_PWR_UP;
      ST_PWR_UP:   if (!enable) nxt = ST_PWR_DOWN; else if (pwr_hit) nxt = ST_VIDEO;
      ST_VIDEO:    if (!enable) nxt = ST_PWR_DOWN; else if (vid_hit) nxt = ST_ON;
      ST_ON:       if (!enable) nxt = ST_BL_DOWN;
      ST_BL_DOWN:  if (bl_done) nxt = ST_PWR_DOWN;
      ST_PWR_DOWN: if (pwr_hit) nxt = ST_OFF;
      default:     nxt = ST_OFF;
    endcase
    if (!timing_ok) nxt = ST_OFF;
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OFF;
      frame_cnt <= '0;
      vsync_q   <= 1'b0;
      panel_pwr <= 1'b0;
      video_en  <= 1'b0;
      bl_en     <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state_q   <= nxt;
      vsync_q   <= vsync;
      if (nxt != state_q)
        frame_cnt <= '0;
      else if (vs_edge && frame_cnt != 8'hFF)
        frame_cnt <= frame_cnt + 8'd1;
      panel_pwr <= (nxt != ST_OFF);
      video_en  <= (nxt == ST_VIDEO) || (nxt == ST_ON) || (nxt == ST_BL_DOWN);
`ifdef BL_FADE_EN
      bl_en     <= (nxt == ST_ON) || ((nxt == ST_BL_DOWN) && !bl_zero);
`else
      bl_en     <= (nxt == ST_ON);
`endif
      ready     <= (nxt == ST_ON);
    end
  end

  panel_bl_pwm #(.PWM_BITS(PWM_BITS)) u_bl (
    .clk        (clk),
    .reset      (reset),
    .vs_edge    (vs_edge),
    .brightness (brightness),
    .bl_en      (bl_en),
`ifdef BL_FADE_EN
    .fade_run   ((state_q == ST_ON) || (state_q == ST_BL_DOWN)),
    .fade_down  (state_q == ST_BL_DOWN),
    .bl_zero    (bl_zero),
`endif
    .bl_pwm     (bl_pwm)
  );
endmodule

// File: doc/dpi_panel_sequencer.md
Name: dpi_panel_sequencer

Overview:
Power/enable sequencer for the 18-bit parallel DPI LCD driven from the GPIO header.
- Sits between the timing generator (vsync, locked) and the panel control pins: panel power, pixel/DE gating, backlight.
- Counts frames to enforce the panel's power-up order (power → video → backlight) and the reverse order at power-down.
- Drives a vsync-synchronised backlight PWM.

Parameters:
PWR_FRAMES, 2, vsync rising edges between panel power-on and video enable (and between video-off and power-off); range 1..255
VIDEO_FRAMES, 4, vsync rising edges between video enable and backlight-on (and between backlight-off and video-off); range 1..255
PWM_BITS, 8, backlight PWM counter/brightness width

Ports:
clk  in  1  pixel clock, same domain as the timing generator
reset  in  1  asynchronous, active-high
enable  in  1  level request: panel on when 1
timing_ok  in  1  PLL locked / timing valid
vsync  in  1  vsync from timing generator, active-high
brightness  in  PWM_BITS  requested backlight duty
panel_pwr  out  1  panel supply enable
video_en  out  1  gates DE and colour; colour forced to 0 when low
bl_en  out  1  backlight driver enable
bl_pwm  out  1  backlight PWM
ready  out  1  1 only in state ON
state  out  3  current FSM state, debug

Behaviour:
- Reset: all outputs 0, state = OFF, frame counter 0, PWM counter 0, latched brightness 0, vsync_q 0.
- Edge detect: vs_edge = vsync & ~vsync_q; vsync_q is registered every cycle.
- Frame counter: 8 bits; cleared on every state transition; increments on vs_edge. An edge in the transition cycle is not counted.
- States: OFF=0, PWR_UP=1, VIDEO=2, ON=3, BL_DOWN=4, PWR_DOWN=5.
- Transitions, one per cycle, registered:
  - OFF → PWR_UP: enable & timing_ok.
  - PWR_UP → VIDEO: PWR_FRAMES-th counted edge. PWR_UP → PWR_DOWN: ~enable.
  - VIDEO → ON: VIDEO_FRAMES-th counted edge. VIDEO → PWR_DOWN: ~enable.
  - ON → BL_DOWN: ~enable.
  - BL_DOWN → PWR_DOWN: VIDEO_FRAMES-th counted edge.
  - PWR_DOWN → OFF: PWR_FRAMES-th counted edge.
- enable reasserted during BL_DOWN/PWR_DOWN is ignored. Shutdown completes; OFF then restarts on the following cycle if enable is still 1.
- timing_ok = 0 in any state has highest priority: next state OFF, all outputs 0 in that same update.
- Outputs are registered with the state, so they change in the same clock edge as the state:
  - panel_pwr = 1 in PWR_UP, VIDEO, ON, BL_DOWN, PWR_DOWN.
  - video_en = 1 in VIDEO, ON, BL_DOWN.
  - bl_en = 1 in ON only.
  - ready = 1 in ON only.
- PWM:
  - PWM_BITS counter free-runs every clk, wraps 2^PWM_BITS-1 → 0.
  - Latched brightness (bl_lvl) updates only on vs_edge.
  - bl_pwm = bl_en & (pwm_cnt < bl_lvl), registered (1-cycle latency).
  - bl_lvl = 0 gives constant 0; 255 gives 255/256 duty.
- Missing vsync: no timeout; the FSM waits indefinitely, and timing_ok is the escape path.

Optional Feature:
BL_FADE_EN
- Defined: on each vs_edge, bl_lvl steps toward brightness by at most 16, saturating, never overshooting.
  - In BL_DOWN the target is 0; the BL_DOWN → PWR_DOWN transition additionally requires bl_lvl == 0.
  - bl_en stays 1 during BL_DOWN while bl_lvl != 0.
  - Entering ON starts from bl_lvl = 0.
- Undefined: bl_lvl loads brightness directly on vs_edge; no ramp.

Decomposition:
- Package dpi_panel_pkg: state enum/encodings (OFF..PWR_DOWN), PWM_BITS default, FADE_STEP = 16.
- One sub-module, panel_bl_pwm: PWM counter, bl_lvl latch and fade logic, compare.
- FSM and frame counter stay in dpi_panel_sequencer.

Test Plan:
- Power-up: reset released, timing_ok=1, enable=1 (defaults) → panel_pwr=1 one cycle later; video_en=1 on the 2nd edge; bl_en=ready=1 on the 4th edge after that; state 1→2→3.
- PWM duty: ON, brightness=64 → after next vsync edge, bl_pwm high exactly 64 of every 256 cycles; brightness=0 → always 0; 255 → 255/256.
- Frame-sync latch: brightness changed 64→200 mid-frame → duty stays 64 until the next vs_edge, then 200.
- Power-down: enable=0 in ON → bl_en=0 next edge; video_en=0 after 4 edges; panel_pwr=0 after 2 more; state 3→4→5→0.
- Abort: timing_ok=0 in VIDEO → next cycle all outputs 0, state OFF; remains OFF until timing_ok=1 and enable=1.
- Early disable: enable=0 in PWR_UP after 1 edge → PWR_DOWN; enable=1 pulsed during PWR_DOWN ignored; OFF after 2 edges, then PWR_UP the next cycle.
